// File: rtl/mem_req_ctrl_if.sv
// Bus bundle between a requester, the mem_req_ctrl front-end and the memory pins.
// The slave modport is the controller's view; master is the surrounding environment.
interface mem_req_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Handshakes: a beat transfers on a rising edge where valid && ready. Once raised,
  // valid and its payload hold until that edge; ready never depends on valid.
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_we_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [STRB_WIDTH-1:0] req_wstrb_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_we_o;
  logic                  rsp_err_o;

  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [STRB_WIDTH-1:0] mem_wstrb_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_wstrb_i,
    input  rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_we_o, rsp_err_o,
    output mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_wstrb_i,
    output rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_we_o, rsp_err_o,
    input  mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Request/response front-end for a single-port synchronous memory with an in-order response FIFO.
// Optional alignment checking is enabled by defining MEM_REQ_CTRL_ALIGN_CHECK_EN.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 3
) (
  input logic           clk_i,
  input logic           arst_ni,
  mem_req_ctrl_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(STRB_WIDTH);
  localparam int PTR_W      = $clog2(RSP_DEPTH);
  localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(RSP_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
    logic                  err;
  } rsp_entry_t;

  logic             s1_valid;
  logic             s1_we;
  logic             s1_err;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  rsp_entry_t       fifo_mem [RSP_DEPTH];
  rsp_entry_t       push_entry;
  rsp_entry_t       head;
  logic             req_ready;
  logic             accept;
  logic             misaligned;
  logic             push;
  logic             pop;
  logic             rsp_valid;

`ifdef MEM_REQ_CTRL_ALIGN_CHECK_EN
  if (OFF_W > 0) begin : g_align_check
    assign misaligned = |bus.req_addr_i[OFF_W-1:0];
  end else begin : g_byte_wide
    assign misaligned = 1'b0;
  end
`else
  assign misaligned = 1'b0;
`endif

  // The entry sitting in s1 already owns a FIFO slot, so it counts toward occupancy.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, s1_valid};
  assign req_ready = arst_ni && (occupancy < DEPTH_W);
  assign accept    = bus.req_valid_i && req_ready;

  assign bus.req_ready_o = req_ready;
  assign bus.mem_addr_o  = bus.req_addr_i;
  assign bus.mem_wdata_o = bus.req_wdata_i;
  assign bus.mem_wstrb_o = bus.req_wstrb_i;
  assign bus.mem_we_o    = accept && bus.req_we_i && !misaligned;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_we  <= bus.req_we_i;
        s1_err <= misaligned;
      end
    end
  end

  // Read data is only meaningful for good reads; writes and errored requests return zero.
  always_comb begin
    push_entry       = '0;
    push_entry.we    = s1_we;
    push_entry.err   = s1_err;
    push_entry.rdata = (s1_we || s1_err) ? '0 : bus.mem_rdata_i;
  end

  assign push      = s1_valid;
  assign rsp_valid = arst_ni && (count != '0);
  assign pop       = rsp_valid && bus.rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The slot at rd_ptr is never the push target while occupied, so the head stays stable.
  assign head            = fifo_mem[rd_ptr];
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_valid ? head.rdata : '0;
  assign bus.rsp_we_o    = rsp_valid && head.we;
`ifdef MEM_REQ_CTRL_ALIGN_CHECK_EN
  assign bus.rsp_err_o   = rsp_valid && head.err;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif
endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request/response front-end that sits directly upstream of the single-port synchronous memory.
- Accepts valid/ready bus requests, drives the memory's addr/we/wdata/wstrb pins, and captures read data one cycle later.
- Returns one ordered response per request through a small response FIFO, so back-to-back traffic is sustained and backpressure from the consumer is absorbed.

Parameters:
- ADDR_WIDTH, 16, address bits; forwarded unchanged to memory.
- DATA_WIDTH, 32, data bits; must be a multiple of 8.
- RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 gives full throughput.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- arst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_addr_i  in  ADDR_WIDTH  request byte address.
- req_we_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_wstrb_i  in  DATA_WIDTH/8  byte write strobes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for write responses.
- rsp_we_o  out  1  echoes req_we of the request being answered.
- rsp_err_o  out  1  error flag; see Optional Feature.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_wstrb_o  out  DATA_WIDTH/8  memory write strobes.
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid the cycle after the address is sampled.

Behaviour:
- Reset:
  - Asynchronous assert clears FIFO pointers, FIFO count and the s1 stage.
  - While arst_ni = 0: req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_we_o = 0, rsp_err_o = 0, mem_we_o = 0.
  - Reset mid-operation discards all in-flight requests and queued responses; no response is issued for them.
- Accept:
  - A request is accepted when req_valid_i && req_ready_o at a rising edge.
  - req_ready_o = arst_ni && ((count + s1_valid) < RSP_DEPTH).
  - req_ready_o is registered-state only; there is no combinational path from rsp_ready_i or req_valid_i.
- Memory drive (combinational from request inputs):
  - mem_addr_o = req_addr_i, mem_wdata_o = req_wdata_i, mem_wstrb_o = req_wstrb_i.
  - mem_we_o = req_valid_i && req_ready_o && req_we_i.
  - Unaccepted cycles may cause harmless reads but never writes.
- Stage s1 (one cycle after accept):
  - s1_valid = 1; s1 holds we and err.
  - In that cycle the response entry {rdata = s1_we ? 0 : mem_rdata_i, we, err} is pushed into the FIFO at the clock edge.
  - Read latency req-accept to rsp_valid_o = 2 cycles when the FIFO is empty.
- FIFO:
  - In-order, RSP_DEPTH entries; pointers wrap from RSP_DEPTH-1 to 0.
  - rsp_valid_o = (count != 0); head entry drives rsp_* outputs.
  - Pop on rsp_valid_o && rsp_ready_i.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Overflow is impossible by construction, because the ready rule reserves a slot for s1. A bench assertion checks this.
- rsp_* outputs must hold stable while rsp_valid_o && !rsp_ready_i.
- Throughput: with rsp_ready_i held at 1, one request is accepted every cycle.
- Full: count = RSP_DEPTH-1 with s1_valid = 1, or count = RSP_DEPTH → req_ready_o = 0 until a pop.

Optional Feature:
- Macro: MEM_REQ_CTRL_ALIGN_CHECK_EN.
- Defined:
  - A request whose addr[log2(DATA_WIDTH/8)-1:0] != 0 is misaligned.
  - A misaligned request is still accepted, but mem_we_o is forced 0.
  - Its response carries rsp_err_o = 1 and rsp_rdata_o = 0.
  - Ordering and latency are identical to a normal request.
- Undefined: no check is made; rsp_err_o is tied to 0; all requests are forwarded.

Test Plan:
- Write addr 0x0010, data 0xDEADBEEF, strb 0xF, then read 0x0010 → write response {we = 1, rdata = 0}, then read response rdata = 0xDEADBEEF two cycles after read accept.
- Partial write strb 0x3 with data 0x0000ABCD over 0x11223344 at 0x0020, then read → rdata = 0x1122ABCD.
- 8 back-to-back reads 0x0000..0x001C with rsp_ready_i = 1 → req_ready_o stays 1, 8 responses in order, one per cycle.
- rsp_ready_i = 0 while issuing reads → exactly 3 accepted, then req_ready_o = 0 and head response held stable. Raising rsp_ready_i drains 3 responses in order and re-enables req_ready_o.
- Assert arst_ni low with 2 queued responses plus 1 in s1 → rsp_valid_o = 0 immediately. After release: count = 0, req_ready_o = 1, no stale responses.
- With MEM_REQ_CTRL_ALIGN_CHECK_EN defined, write to 0x0012 → mem_we_o = 0 and response err = 1. A following read of 0x0010 returns the prior contents unchanged.
